// File: rtl/fifo_pkg.sv
// Shared status and sticky-error types for the register-array FIFO.
// Leaf package; no logic, no latency.
package fifo_pkg;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } status_t;

   typedef struct packed {
      logic overflow;
      logic underflow;
   } err_t;

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy, flag and sticky-error control for reg_fifo; all state updates on the same edge.
// Writes into a full queue are dropped unless a pop happens in the same cycle.
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 2,
   parameter int AF_MARGIN  = 1,
   parameter int AE_MARGIN  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr,
   input  logic                  rd,
   input  logic                  flush,
   input  logic                  clr_err,
   output logic                  wr_accepted,
   output logic [ADDR_WIDTH-1:0] w_ptr,
   output logic [ADDR_WIDTH-1:0] r_ptr,
   output logic [ADDR_WIDTH:0]   count,
   output status_t               status,
   output err_t                  err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CNT_W = ADDR_WIDTH + 1;

   logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
   logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   status_t               status_q, status_d;
   err_t                  err_q, err_d;
   logic                  wr_acc, rd_acc;

   // Flags are derived from the next count so they stay in step with it.
   function automatic status_t status_of(input logic [CNT_W-1:0] c);
      status_t s;
      s.full         = (c == CNT_W'(DEPTH));
      s.empty        = (c == '0);
      s.almost_full  = (int'(c) >= DEPTH - AF_MARGIN);
      s.almost_empty = (int'(c) <= AE_MARGIN);
      return s;
   endfunction

   always_comb begin
      rd_acc  = rd && !status_q.empty && !flush;
      wr_acc  = wr && (!status_q.full || rd) && !flush;
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      count_d = count_q;
      if (wr_acc) w_ptr_d = w_ptr_q + 1'b1;
      if (rd_acc) r_ptr_d = r_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (flush) begin
         w_ptr_d = '0;
         r_ptr_d = '0;
         count_d = '0;
      end
      status_d = status_of(count_d);
      // A fresh error event outranks a simultaneous clear.
      err_d = clr_err ? '0 : err_q;
      if (wr && status_q.full && !rd && !flush) err_d.overflow  = 1'b1;
      if (rd && status_q.empty && !flush)       err_d.underflow = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_ptr_q  <= '0;
         r_ptr_q  <= '0;
         count_q  <= '0;
         status_q <= status_of('0);
         err_q    <= '0;
      end else begin
         w_ptr_q  <= w_ptr_d;
         r_ptr_q  <= r_ptr_d;
         count_q  <= count_d;
         status_q <= status_d;
         err_q    <= err_d;
      end
   end

   assign wr_accepted = wr_acc;
   assign w_ptr       = w_ptr_q;
   assign r_ptr       = r_ptr_q;
   assign count       = count_q;
   assign status      = status_q;
   assign err         = err_q;

endmodule

// File: rtl/reg_fifo.sv
// Register-array FIFO with first-word fall-through read; written word is at the head one cycle after its write edge.
// Full without a same-cycle pop drops the write and raises sticky overflow; pop on empty raises underflow.
module reg_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 2,
   parameter int AF_MARGIN  = 1,
   parameter int AE_MARGIN  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] r_data,
   input  logic                  flush,
   input  logic                  clr_err,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic                  wr_accepted;
   logic [ADDR_WIDTH-1:0] w_ptr, r_ptr;
   status_t               status;
   err_t                  err;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   fifo_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .AF_MARGIN  (AF_MARGIN),
      .AE_MARGIN  (AE_MARGIN)
   ) u_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr          (wr),
      .rd          (rd),
      .flush       (flush),
      .clr_err     (clr_err),
      .wr_accepted (wr_accepted),
      .w_ptr       (w_ptr),
      .r_ptr       (r_ptr),
      .count       (count),
      .status      (status),
      .err         (err)
   );

   // Storage is deliberately not reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (wr_accepted) mem_q[w_ptr] <= w_data;
   end

   assign r_data       = mem_q[r_ptr];
   assign full         = status.full;
   assign empty        = status.empty;
   assign almost_full  = status.almost_full;
   assign almost_empty = status.almost_empty;
   assign overflow     = err.overflow;
   assign underflow    = err.underflow;

endmodule

// File: doc/reg_fifo.md
REG_FIFO -- requirements
Module: reg_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 2, SHALL set the storage depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter AF_MARGIN, default 1, SHALL set the almost_full threshold; legal range 0..DEPTH-1.
REQ-004 Parameter AE_MARGIN, default 1, SHALL set the almost_empty threshold; legal range 0..DEPTH-1.
REQ-005 clk  input  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-006 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 wr  input  1  SHALL be the write request, sampled at the clk rising edge.
REQ-008 w_data  input  DATA_WIDTH  SHALL be the data written when a write is accepted.
REQ-009 rd  input  1  SHALL be the read/pop request, sampled at the clk rising edge.
REQ-010 r_data  output  DATA_WIDTH  SHALL be the head-of-queue word (first-word fall-through).
REQ-011 flush  input  1  SHALL be a synchronous clear of queue state.
REQ-012 clr_err  input  1  SHALL be a synchronous clear of the sticky error flags.
REQ-013 full, empty, almost_full, almost_empty  output  1 each  SHALL be the status flags.
REQ-014 count  output  ADDR_WIDTH+1  SHALL be the current occupancy, 0..DEPTH.
REQ-015 overflow, underflow  output  1 each  SHALL be the sticky error flags.

Function
REQ-016 Storage SHALL be a DEPTH x DATA_WIDTH array addressed by w_ptr and r_ptr, each ADDR_WIDTH bits, wrapping modulo DEPTH.
REQ-017 r_data SHALL combinationally equal array[r_ptr]; r_data is undefined while empty.
REQ-018 Write accepted when wr=1 and (full=0 or rd=1): store w_data at w_ptr, increment w_ptr.
REQ-019 Read accepted when rd=1 and empty=0: increment r_ptr.
REQ-020 Write and read both accepted in one cycle: count unchanged; in the full case the popped word leaves and the new word enters.
REQ-021 wr=1, rd=1 while empty: write accepted, read rejected, underflow set; count becomes 1.
REQ-022 wr=1 while full with rd=0: write dropped, array and pointers unchanged, overflow set.
REQ-023 rd=1 while empty with wr=0: no state change except underflow set.
REQ-024 count SHALL increment on write-only accept, decrement on read-only accept, hold otherwise.
REQ-025 full = (count==DEPTH); empty = (count==0); almost_full = (count >= DEPTH-AF_MARGIN); almost_empty = (count <= AE_MARGIN); all registered, consistent with count in the same cycle.
REQ-026 flush=1 SHALL set w_ptr, r_ptr, count to 0 at the next edge and ignore wr/rd that cycle; array contents untouched; error flags untouched.
REQ-027 clr_err=1 SHALL clear overflow and underflow; an error event in the same cycle SHALL win (flag remains set).
REQ-028 Latency: written word visible on r_data the cycle after the write edge when it is the head; flags and count update at the same edge as the pointers.

Reset
REQ-029 rst_n=0 SHALL immediately set w_ptr=0, r_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0 (almost_full=1 if AF_MARGIN=DEPTH-1 not applicable at count 0 unless DEPTH-AF_MARGIN<=0), overflow=0, underflow=0.
REQ-030 Storage array SHALL NOT be reset; reset mid-operation discards all queued words.
REQ-031 Deassertion of rst_n SHALL take effect on the next rising clk edge with no extra idle cycles.

Structure
REQ-032 A shared package fifo_pkg SHALL hold a status struct type (full, empty, almost_full, almost_empty) and the error-flag struct type (overflow, underflow).
REQ-033 Pointer/count/flag logic SHALL be one sub-module fifo_ctrl; reg_fifo instantiates fifo_ctrl plus the storage array.
REQ-034 fifo_ctrl SHALL drive the write enable as wr_accepted, so storage writes only on accepted writes.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, AF_MARGIN=1, AE_MARGIN=1)
REQ-035 Write 0x11,0x22,0x33,0x44 -> full=1, count=4, almost_full=1 after 3rd write; reads return 0x11..0x44 in order, empty=1 at end.
REQ-036 Full, wr=1 w_data=0x55 rd=0 -> overflow=1, count=4, subsequent reads return 0x11..0x44 only.
REQ-037 Full, wr=1 w_data=0x55 rd=1 -> count=4, r_data=0x22 next cycle, 0x55 emerges as 4th read.
REQ-038 Empty, wr=1 w_data=0xA5 rd=1 -> underflow=1, count=1, r_data=0xA5.
REQ-039 Six writes/reads wrapping pointers past 3 -> data order preserved; flush with count=3 -> count=0, empty=1, overflow/underflow unchanged.
REQ-040 rst_n pulled low mid-clock with count=2, overflow=1 -> count=0, empty=1, overflow=0 before next edge.
